ask_mod_param: RTL and testbench
================================

ASK_MOD_PARAM -- requirements
Module: ask_mod_param

Interface
- REQ-001 SHALL have parameter WORD_W, default 8: payload word width in bits, 2..16.
- REQ-002 SHALL have parameter BPS, default 1: bits per symbol (1 = OOK, 2 = 4-ASK, 3 = 8-ASK); WORD_W % BPS == 0.
- REQ-003 SHALL have parameter SPB, default 4: clock cycles per symbol, >= 2.
- REQ-004 SHALL have parameter HALF_PER, default 2: carrier half-period in clocks, >= 1.
- REQ-005 SHALL have parameter AMP_W, default 4: amplitude output width, >= BPS.
- REQ-006 SHALL have clk, input, 1: single clock; all logic on its rising edge.
- REQ-007 SHALL have rst, input, 1: asynchronous, active-high reset.
- REQ-008 SHALL have load, input, 1: start pulse; honoured only in IDLE.
- REQ-009 SHALL have prbs_en, input, 1: source select sampled with load; 1 = internal LFSR, 0 = word_in.
- REQ-010 SHALL have stop, input, 1: pulse; ends session at the next word boundary.
- REQ-011 SHALL have word_in, input, WORD_W: external payload word.
- REQ-012 SHALL have word_valid / word_ready, input / output, 1: word accepted when both high on a clock edge.
- REQ-013 SHALL have amp_out, output, AMP_W: current symbol amplitude level.
- REQ-014 SHALL have mod_out, output, AMP_W: amp_out while carrier high, else 0.
- REQ-015 SHALL have carrier_out, output, 1: square-wave carrier.
- REQ-016 SHALL have xor_result, output, 1: MSB of current symbol XOR carrier_out.
- REQ-017 SHALL have new_word, output, 1: one-cycle pulse on the first cycle of each word.
- REQ-018 SHALL have busy, output, 1: high in all states except IDLE.

Function
- REQ-019 SHALL implement FSM states IDLE and SEND; IDLE -> SEND on load with a word available (prbs_en=1, or word_valid=1); SEND -> IDLE at a word boundary when stop is latched, or when prbs_en=0 and word_valid=0.
- REQ-020 SHALL hold word_ready high in IDLE when prbs_en=0, and in SEND only on the last cycle of the last symbol of a word with prbs_en=0 and no stop latched.
- REQ-021 SHALL transmit symbols MSB-first, WORD_W/BPS symbols per word, each held exactly SPB cycles; the first symbol appears the cycle after acceptance (latency 1).
- REQ-022 SHALL map symbol value k to amp_out = k * (2^AMP_W-1) / (2^BPS-1), using a constant table and no runtime divider.
- REQ-023 SHALL toggle carrier_out every HALF_PER cycles; it is free-running from reset and is not resynchronised to words.
- REQ-024 SHALL send back-to-back words with no idle cycle when the next word is available at the boundary, pulsing new_word for each one.
- REQ-025 SHALL, in PRBS mode, use a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1); word = LFSR[WORD_W-1:0]; the LFSR advances one step per loaded word.
- REQ-026 SHALL latch a stop pulse arriving mid-word; the current word completes, then IDLE is entered; stop in IDLE is ignored.
- REQ-027 SHALL ignore load in SEND.
- REQ-028 SHALL hold amp_out, mod_out and xor_result at 0 in IDLE.

Reset
- REQ-029 SHALL, on rst, immediately set: state IDLE; amp_out, mod_out, xor_result, new_word, busy = 0; carrier_out = 0; LFSR = 16'hACE1; symbol and cycle counters = 0; stop latch cleared.
- REQ-030 SHALL, on rst mid-word, abort the word with no completion and no new_word pulse.

Structure
- REQ-031 SHALL place the LFSR seed and taps, the amplitude-table function, and the state enumeration in a shared package ask_pkg.
- REQ-032 SHALL implement the LFSR as sub-module ask_lfsr (enable in, 16-bit state out).

Verification
- REQ-033 SHALL cover: defaults, prbs_en=0, word_in=8'hA5, load pulse -> new_word once; amp_out sequence F,0,F,0,0,F,0,F, 4 cycles each; then IDLE.
- REQ-034 SHALL cover: BPS=2, AMP_W=4, word_in=8'h1B -> amp_out 0,5,A,F, 4 cycles each.
- REQ-035 SHALL cover: prbs_en=1, load -> first word 8'hE1, second word = LFSR step of 16'hACE1 low byte, no gap between words; stop mid-word 2 -> IDLE after word 2.
- REQ-036 SHALL cover: word_valid held high with 3 queued words -> 3 new_word pulses spaced exactly 32 cycles apart; word_valid low at boundary -> IDLE.
- REQ-037 SHALL cover: rst asserted mid-symbol -> all outputs 0 in the same cycle; a following load restarts cleanly.
- REQ-038 SHALL cover: mod_out == (carrier_out ? amp_out : 0) and xor_result consistent with the current symbol MSB on every cycle (checked as an assertion).

Source files
------------

// File: rtl/ask_pkg.sv
// Shared definitions for the ASK modulator: state encoding, LFSR constants
// and the symbol-to-amplitude mapping.
package ask_pkg;

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int amp_level(input int k, input int bps, input int amp_w);
    return (k * ((1 << amp_w) - 1)) / ((1 << bps) - 1);
  endfunction

endpackage

// File: rtl/ask_lfsr.sv
// 16-bit Fibonacci LFSR payload source; advances one step per enabled cycle.
module ask_lfsr
  import ask_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/ask_mod_param.sv
// Parameterised ASK modulator: serialises payload words MSB-first into
// amplitude symbols and gates them with a free-running square carrier.
module ask_mod_param
  import ask_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int BPS      = 1,
  parameter int SPB      = 4,
  parameter int HALF_PER = 2,
  parameter int AMP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              prbs_en,
  input  logic              stop,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [AMP_W-1:0]  amp_out,
  output logic [AMP_W-1:0]  mod_out,
  output logic              carrier_out,
  output logic              xor_result,
  output logic              new_word,
  output logic              busy
);

  localparam int NSYM  = WORD_W / BPS;
  localparam int NLEV  = 1 << BPS;
  localparam int CYC_W = $clog2(SPB);
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int HP_W  = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SPB - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSYM - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PER - 1);

  state_e            state_q;
  logic              mode_prbs_q;
  logic              stop_q;
  logic              new_word_q;
  logic [WORD_W-1:0] shift_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [SYM_W-1:0]  sym_q;
  logic [HP_W-1:0]   half_q;
  logic              carrier_q;

  logic [15:0]       lfsr_state;
  logic              lfsr_unused;
  logic [AMP_W-1:0]  amp_tab [NLEV];
  logic [BPS-1:0]    sym_val;
  logic              last_cyc;
  logic              stop_eff;
  logic              start;
  logic              chain;
  logic              accept;
  logic              use_prbs;
  logic [WORD_W-1:0] word_d;

  for (genvar k = 0; k < NLEV; k++) begin : g_amp
    assign amp_tab[k] = AMP_W'(amp_level(k, BPS, AMP_W));
  end

  ask_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept && use_prbs),
    .state_o (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state;

  // A stop arriving on the boundary cycle itself counts as already latched.
  assign last_cyc = (state_q == SEND) && (cyc_q == CYC_LAST) && (sym_q == SYM_LAST);
  assign stop_eff = stop_q | stop;
  assign start    = (state_q == IDLE) && load && (prbs_en || word_valid);
  assign chain    = last_cyc && !stop_eff && (mode_prbs_q || word_valid);
  assign accept   = start || chain;
  assign use_prbs = (state_q == IDLE) ? prbs_en : mode_prbs_q;
  assign word_d   = use_prbs ? lfsr_state[WORD_W-1:0] : word_in;

  assign word_ready = (state_q == IDLE) ? !prbs_en
                                        : (last_cyc && !mode_prbs_q && !stop_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_prbs_q <= 1'b0;
      stop_q      <= 1'b0;
      new_word_q  <= 1'b0;
      shift_q     <= '0;
      cyc_q       <= '0;
      sym_q       <= '0;
    end else begin
      new_word_q <= accept;
      if (accept) begin
        state_q     <= SEND;
        mode_prbs_q <= use_prbs;
        stop_q      <= 1'b0;
        shift_q     <= word_d;
        cyc_q       <= '0;
        sym_q       <= '0;
      end else if (state_q == SEND) begin
        if (stop) stop_q <= 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_q <= '0;
          if (sym_q == SYM_LAST) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
            sym_q   <= '0;
          end else begin
            sym_q   <= sym_q + SYM_W'(1);
            shift_q <= shift_q << BPS;
          end
        end else begin
          cyc_q <= cyc_q + CYC_W'(1);
        end
      end
    end
  end

  // The carrier runs from reset regardless of word framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q    <= '0;
      carrier_q <= 1'b0;
    end else if (half_q == HP_LAST) begin
      half_q    <= '0;
      carrier_q <= ~carrier_q;
    end else begin
      half_q <= half_q + HP_W'(1);
    end
  end

  assign sym_val     = shift_q[WORD_W-1 -: BPS];
  assign busy        = (state_q == SEND);
  assign amp_out     = busy ? amp_tab[sym_val] : '0;
  assign mod_out     = carrier_q ? amp_out : '0;
  assign carrier_out = carrier_q;
  assign xor_result  = busy & (shift_q[WORD_W-1] ^ carrier_q);
  assign new_word    = new_word_q;

endmodule

// File: tb/tb_ask_mod_param.sv
// Self-checking bench for ask_mod_param: default OOK instance plus a 4-ASK
// instance, compared against a word/symbol level reference model.
module tb_ask_mod_param;

  localparam int WW = 8;
  localparam int AW = 4;
  localparam int HP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0, prbs_en = 1'b0, stop = 1'b0, word_valid = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic word_ready, carrier_out, xor_result, new_word, busy;
  logic [AW-1:0] amp_out, mod_out;

  logic load2 = 1'b0, prbs2 = 1'b0, stop2 = 1'b0, word_valid2 = 1'b0;
  logic [WW-1:0] word_in2 = '0;
  logic word_ready2, carrier_out2, xor_result2, new_word2, busy2;
  logic [AW-1:0] amp_out2, mod_out2;

  int vectors = 0;
  int miscompares = 0;
  int edgeCnt = 0;

  always #5 clk = ~clk;

  ask_mod_param dut (
    .clk(clk), .rst(rst), .load(load), .prbs_en(prbs_en), .stop(stop),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .amp_out(amp_out), .mod_out(mod_out), .carrier_out(carrier_out),
    .xor_result(xor_result), .new_word(new_word), .busy(busy)
  );

  ask_mod_param #(.WORD_W(8), .BPS(2), .SPB(4), .HALF_PER(2), .AMP_W(4)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .prbs_en(prbs2), .stop(stop2),
    .word_in(word_in2), .word_valid(word_valid2), .word_ready(word_ready2),
    .amp_out(amp_out2), .mod_out(mod_out2), .carrier_out(carrier_out2),
    .xor_result(xor_result2), .new_word(new_word2), .busy(busy2)
  );

  function automatic int ampOf(input int k, input int bps, input int aw);
    return k * ((1 << aw) - 1) / ((1 << bps) - 1);
  endfunction

  function automatic int symOf(input int word, input int s, input int ww, input int bps);
    return (word >> (ww - bps * (s + 1))) & ((1 << bps) - 1);
  endfunction

  // Polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  // Every cycle: carrier timing, mod_out gating and xor_result versus symbol MSB.
  always @(negedge clk) begin
    if (!rst) begin
      logic expCar, expMsb, expXor;
      logic [AW-1:0] expMod;
      expCar = ((edgeCnt / HP) % 2) == 1;
      expMsb = busy && (int'(amp_out) >= ampOf(1, 1, AW));
      expXor = busy && (expMsb ^ carrier_out);
      expMod = carrier_out ? amp_out : '0;
      vectors += 3;
      assert (carrier_out === expCar) else begin
        miscompares++;
        $display("[TB] FAIL carrier t=%0t got %b expected %b", $time, carrier_out, expCar);
      end
      assert (mod_out === expMod) else begin
        miscompares++;
        $display("[TB] FAIL mod_out t=%0t got %h expected %h", $time, mod_out, expMod);
      end
      assert (xor_result === expXor) else begin
        miscompares++;
        $display("[TB] FAIL xor_result t=%0t got %b expected %b", $time, xor_result, expXor);
      end
    end
  end

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({amp_out, mod_out, xor_result, new_word, busy, carrier_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h%h%b%b%b%b expected all zero",
               amp_out, mod_out, xor_result, new_word, busy, carrier_out);
    end
    vectors++;
    if (word_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got %b expected 1", word_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ook_a5();
    logic [7:0] w = 8'hA5;
    int nw = 0;
    int expAmp;
    @(negedge clk);
    prbs_en = 1'b0; word_in = w; word_valid = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; word_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expAmp = ampOf(symOf(w, i / 4, WW, 1), 1, AW);
      vectors++;
      if (amp_out !== AW'(expAmp)) begin
        miscompares++;
        $display("[TB] FAIL ook_amp cyc %0d got %h expected %h", i, amp_out, expAmp);
      end
      vectors++;
      if (word_ready !== (i == 31)) begin
        miscompares++;
        $display("[TB] FAIL ook_ready cyc %0d got %b expected %b", i, word_ready, i == 31);
      end
      if (new_word) nw++;
      load    = (i == 10);
      prbs_en = (i == 10);
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || amp_out !== '0) begin
      miscompares++;
      $display("[TB] FAIL ook_idle got busy=%b amp=%h expected busy=0 amp=0", busy, amp_out);
    end
    vectors++;
    if (nw != 1) begin
      miscompares++;
      $display("[TB] FAIL ook_new_word got %0d pulses expected 1", nw);
    end
  endtask

  task automatic test_bps2();
    logic [7:0] w = 8'h1B;
    int expAmp;
    @(negedge clk);
    prbs2 = 1'b0; word_in2 = w; word_valid2 = 1'b1; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0; word_valid2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expAmp = ampOf(symOf(w, i / 4, WW, 2), 2, AW);
      vectors++;
      if (amp_out2 !== AW'(expAmp)) begin
        miscompares++;
        $display("[TB] FAIL ask4_amp cyc %0d got %h expected %h", i, amp_out2, expAmp);
      end
      vectors++;
      if (mod_out2 !== (carrier_out2 ? amp_out2 : AW'(0)) || carrier_out2 !== carrier_out) begin
        miscompares++;
        $display("[TB] FAIL ask4_mod cyc %0d got mod=%h car=%b expected car=%b",
                 i, mod_out2, carrier_out2, carrier_out);
      end
      vectors++;
      if (xor_result2 !== ((expAmp >= ampOf(2, 2, AW)) ^ carrier_out2)) begin
        miscompares++;
        $display("[TB] FAIL ask4_xor cyc %0d got %b", i, xor_result2);
      end
      vectors++;
      if (new_word2 !== (i == 0) || word_ready2 !== (i == 15) || busy2 !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL ask4_ctrl cyc %0d got nw=%b rdy=%b busy=%b", i, new_word2, word_ready2, busy2);
      end
      @(negedge clk);
    end
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ask4_idle got busy=%b expected 0", busy2);
    end
  endtask

  task automatic test_prbs_stop();
    logic [15:0] lfsrM;
    logic [7:0] words [2];
    int expAmp;
    doReset();
    lfsrM = 16'hACE1;
    words[0] = lfsrM[7:0];
    lfsrM = lfsrNext(lfsrM);
    words[1] = lfsrM[7:0];
    prbs_en = 1'b1; word_valid = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0; prbs_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expAmp = ampOf(symOf(words[i / 32], (i % 32) / 4, WW, 1), 1, AW);
      vectors++;
      if (amp_out !== AW'(expAmp)) begin
        miscompares++;
        $display("[TB] FAIL prbs_amp cyc %0d got %h expected %h", i, amp_out, expAmp);
      end
      vectors++;
      if (new_word !== (i % 32 == 0) || busy !== 1'b1 || word_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL prbs_ctrl cyc %0d got nw=%b busy=%b rdy=%b", i, new_word, busy, word_ready);
      end
      stop = (i == 40);
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || new_word !== 1'b0 || word_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL prbs_stop got busy=%b nw=%b rdy=%b expected 0 0 1", busy, new_word, word_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int idx;
    int lastPulse = -1;
    int pulses = 0;
    int expAmp;
    bit pop;
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom_range(0, 255));
    // A stop seen while idle must not cut the coming session short.
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    prbs_en = 1'b0; word_in = words[0]; word_valid = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; idx = 1; word_in = words[1];
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      expAmp = ampOf(symOf(words[i / 32], (i % 32) / 4, WW, 1), 1, AW);
      vectors++;
      if (amp_out !== AW'(expAmp)) begin
        miscompares++;
        $display("[TB] FAIL b2b_amp cyc %0d got %h expected %h", i, amp_out, expAmp);
      end
      vectors++;
      if (new_word !== (i % 32 == 0) || busy !== 1'b1 || word_ready !== (i % 32 == 31)) begin
        miscompares++;
        $display("[TB] FAIL b2b_ctrl cyc %0d got nw=%b busy=%b rdy=%b", i, new_word, busy, word_ready);
      end
      if (new_word) begin
        pulses++;
        if (lastPulse >= 0) begin
          vectors++;
          if (i - lastPulse != 32) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing got %0d expected 32", i - lastPulse);
          end
        end
        lastPulse = i;
      end
      pop = word_valid && word_ready;
      @(posedge clk); #1;
      if (pop) begin
        idx++;
        if (idx < 3) word_in = words[idx];
        else         word_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pulses != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_end got busy=%b pulses=%0d expected 0 3", busy, pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    int nw = 0;
    int expAmp;
    @(negedge clk);
    prbs_en = 1'b0; word_in = 8'($urandom_range(0, 255)); word_valid = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; word_valid = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    vectors++;
    if ({amp_out, mod_out, xor_result, new_word, busy, carrier_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_outputs got %h%h%b%b%b%b expected all zero",
               amp_out, mod_out, xor_result, new_word, busy, carrier_out);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vectors++;
      if (busy !== 1'b0 || new_word !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midrst_quiet cyc %0d got busy=%b nw=%b expected 0 0", i, busy, new_word);
      end
      @(negedge clk);
    end
    w = 8'($urandom_range(0, 255));
    word_in = w; word_valid = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; word_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expAmp = ampOf(symOf(w, i / 4, WW, 1), 1, AW);
      vectors++;
      if (amp_out !== AW'(expAmp)) begin
        miscompares++;
        $display("[TB] FAIL restart_amp cyc %0d got %h expected %h", i, amp_out, expAmp);
      end
      if (new_word) nw++;
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || nw != 1) begin
      miscompares++;
      $display("[TB] FAIL restart_end got busy=%b pulses=%0d expected 0 1", busy, nw);
    end
  endtask

  initial begin
    test_reset();
    test_ook_a5();
    test_bps2();
    test_prbs_stop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
